// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: funct3 opcodes and arbiter FSM states.
package alu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SLL  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SRL  = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu_arb_pick.sv
// One-hot grant picker: rotates requests so ptr_i is bit 0, takes the lowest set bit,
// then rotates the grant back into requester order.
module alu_arb_pick #(
  parameter int NREQ = 2,
  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o
);

  logic [NREQ-1:0] rotReq;
  logic [NREQ-1:0] rotGnt;
  logic [PW-1:0]   srcIdx;

  always_comb begin
    rotReq = '0;
    gnt_o  = '0;
    srcIdx = '0;
    for (int i = 0; i < NREQ; i++) begin
      srcIdx    = PW'((i + int'(ptr_i)) % NREQ);
      rotReq[i] = req_i[srcIdx];
    end
    // Isolating the lowest set bit gives fixed priority in the rotated frame.
    rotGnt = rotReq & (-rotReq);
    for (int i = 0; i < NREQ; i++) begin
      srcIdx        = PW'((i + int'(ptr_i)) % NREQ);
      gnt_o[srcIdx] = rotGnt[i];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NREQ requesters, one operation in flight at a time.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int XLEN    = 32,
  parameter int ALU_LAT = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [NREQ*XLEN-1:0] req_rs1_i,
  input  logic [NREQ*XLEN-1:0] req_rs2_i,
  input  logic [NREQ*3-1:0]    req_funct3_i,
  input  logic [NREQ-1:0]      req_funct7_i,
  output logic [NREQ-1:0]      rsp_valid_o,
  input  logic [NREQ-1:0]      rsp_ready_i,
  output logic [XLEN-1:0]      rsp_rd_o,
  output logic                 rsp_z_o,
  output logic [XLEN-1:0]      alu_rs1_o,
  output logic [XLEN-1:0]      alu_rs2_o,
  output logic [2:0]           alu_funct3_o,
  output logic                 alu_funct7_o,
  input  logic [XLEN-1:0]      alu_rd_i,
  input  logic                 alu_z_i
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   ownerIdx_q, ownerIdx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] aluRs1_q, aluRs1_d, aluRs2_q, aluRs2_d;
  logic [2:0]      aluF3_q, aluF3_d;
  logic            aluF7_q, aluF7_d;
  logic [XLEN-1:0] rspRd_q, rspRd_d;
  logic            rspZ_q, rspZ_d;

  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grantIdx;
  logic [IW-1:0]   startPtr;
  logic            accept;
  logic [XLEN-1:0] selRs1, selRs2;
  logic [2:0]      selF3;
  logic            selF7;

`ifdef ALU_ARB_RR_EN
  logic [IW-1:0] ptr_q, ptr_d;

  assign startPtr = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = IW'((int'(grantIdx) + 1) % NREQ);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`else
  assign startPtr = '0;
`endif

  alu_arb_pick #(.NREQ(NREQ)) u_pick (
    .req_i (req_valid_i),
    .ptr_i (startPtr),
    .gnt_o (grant)
  );

  always_comb begin
    grantIdx = '0;
    selRs1   = '0;
    selRs2   = '0;
    selF3    = '0;
    selF7    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        grantIdx = IW'(i);
        selRs1   = req_rs1_i[i*XLEN +: XLEN];
        selRs2   = req_rs2_i[i*XLEN +: XLEN];
        selF3    = req_funct3_i[i*3 +: 3];
        selF7    = req_funct7_i[i];
      end
    end
  end

  assign req_ready_o = (state_q == IDLE && !rst_i) ? grant : '0;
  assign accept      = |(req_valid_i & req_ready_o);

  always_comb begin
    state_d    = state_q;
    ownerIdx_d = ownerIdx_q;
    cnt_d      = cnt_q;
    aluRs1_d   = aluRs1_q;
    aluRs2_d   = aluRs2_q;
    aluF3_d    = aluF3_q;
    aluF7_d    = aluF7_q;
    rspRd_d    = rspRd_q;
    rspZ_d     = rspZ_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          aluRs1_d   = selRs1;
          aluRs2_d   = selRs2;
          aluF3_d    = selF3;
          aluF7_d    = selF7;
          ownerIdx_d = grantIdx;
          cnt_d      = CW'(ALU_LAT);
          state_d    = BUSY;
        end
      end
      BUSY: begin
        // Operands stay frozen here so a registered ALU sees them for ALU_LAT edges.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          rspRd_d = alu_rd_i;
          rspZ_d  = alu_z_i;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i[ownerIdx_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rsp_valid_o = '0;
    if (state_q == RESP) rsp_valid_o[ownerIdx_q] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      ownerIdx_q <= '0;
      cnt_q      <= '0;
      aluRs1_q   <= '0;
      aluRs2_q   <= '0;
      aluF3_q    <= ALU_ADD;
      aluF7_q    <= 1'b0;
      rspRd_q    <= '0;
      rspZ_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ownerIdx_q <= ownerIdx_d;
      cnt_q      <= cnt_d;
      aluRs1_q   <= aluRs1_d;
      aluRs2_q   <= aluRs2_d;
      aluF3_q    <= aluF3_d;
      aluF7_q    <= aluF7_d;
      rspRd_q    <= rspRd_d;
      rspZ_q     <= rspZ_d;
    end
  end

  assign rsp_rd_o     = rspRd_q;
  assign rsp_z_o      = rspZ_q;
  assign alu_rs1_o    = aluRs1_q;
  assign alu_rs2_o    = aluRs2_q;
  assign alu_funct3_o = aluF3_q;
  assign alu_funct7_o = aluF7_q;

endmodule
